// File: rtl/mx4_rr_scheduler_if.sv
// Requester/sink bundle for the round-robin CC_MX4 scheduler.
// The master side drives requests and sink readiness; the slave side is the scheduler.
interface mx4_rr_scheduler_if #(
    parameter int CNT_W = 4
);
    logic [3:0]       req;
    logic [3:0]       last;
    logic [3:0]       d;
    logic             y_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             y;
    logic             y_valid;
    logic [CNT_W-1:0] grant_cnt;

    modport master (
        output req, last, d, y_ready,
        input  gnt, sel, y, y_valid, grant_cnt
    );

    modport slave (
        input  req, last, d, y_ready,
        output gnt, sel, y, y_valid, grant_cnt
    );
endinterface

// File: rtl/mx4_rr_scheduler.sv
// Round-robin burst scheduler sharing one 4:1 mux (CC_MX4) between four 1-bit requesters.
// The owner index is registered and drives the mux selects directly.
module mx4_rr_scheduler #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    mx4_rr_scheduler_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       prev_q, prev_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_W-1:0] beat_inc;
    logic [1:0]       winner;
    logic             y_valid;
    logic             xfer;

    // First set request scanning prev+1, prev+2, prev+3, prev (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] w;
        logic       found;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner   = rr_pick(bus.req, prev_q);
    assign beat_inc = beat_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        prev_d      = prev_q;
        beat_d      = beat_q;
        grant_cnt_d = grant_cnt_q;
        y_valid     = 1'b0;
        xfer        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_d     = GRANT;
                    sel_d       = winner;
                    gnt_d       = 4'b0001 << winner;
                    prev_d      = winner;
                    beat_d      = '0;
                    grant_cnt_d = grant_cnt_q + CNT_W'(1);
                end
            end
            GRANT: begin
                // Reset gates the handshake so no beat can slip through an aborted burst.
                y_valid = bus.req[sel_q] && !rst;
                xfer    = y_valid && bus.y_ready;
                if (xfer) begin
                    beat_d = beat_inc;
                end
                if (!bus.req[sel_q] ||
                    (xfer && (bus.last[sel_q] || beat_inc == CNT_W'(MAX_BURST)))) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            sel_q       <= 2'b00;
            prev_q      <= 2'd3;
            beat_q      <= '0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            prev_q      <= prev_d;
            beat_q      <= beat_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // Data path is exactly one CC_MX4: S0 = sel[0], S1 = sel[1], D0..D3 = d.
    assign bus.y = sel_q[1] ? (sel_q[0] ? bus.d[3] : bus.d[2])
                            : (sel_q[0] ? bus.d[1] : bus.d[0]);

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.y_valid   = y_valid;
    assign bus.grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_mx4_rr_scheduler.sv
// Directed bench for mx4_rr_scheduler: stimulus pushes expected grants and beats,
// a monitor pops and compares them whenever the DUT grants or transfers.
module tb_mx4_rr_scheduler;

    localparam int CNT_W = 4;

    typedef struct {
        logic [1:0] sel;
        logic       y;
    } beat_t;

    typedef struct {
        logic [3:0]       gnt;
        logic [CNT_W-1:0] cnt;
    } grant_t;

    logic clk;
    logic rst;
    logic stim_done;
    int   checks;
    int   errors;

    beat_t  beat_q[$];
    grant_t grant_q[$];

    mx4_rr_scheduler_if #(.CNT_W(CNT_W)) bus ();

    mx4_rr_scheduler #(
        .MAX_BURST(4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_grant(input logic [3:0] g, input int c);
        grant_t e;
        e.gnt = g;
        e.cnt = CNT_W'(c);
        grant_q.push_back(e);
    endtask

    task automatic push_beat(input logic [1:0] s, input logic yv);
        beat_t e;
        e.sel = s;
        e.y   = yv;
        beat_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [3:0] gnt_last;
        beat_t      b;
        grant_t     g;
        gnt_last = 4'b0000;
        while (!stim_done) begin
            @(negedge clk);
            check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            if (bus.y_valid) check("valid_owner", 32'(bus.gnt[bus.sel]), 32'd1);
            if (bus.gnt != 4'b0000 && gnt_last == 4'b0000) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got gnt=%b expected none", bus.gnt);
                end else begin
                    g = grant_q.pop_front();
                    check("grant_gnt", 32'(bus.gnt), 32'(g.gnt));
                    check("grant_cnt", 32'(bus.grant_cnt), 32'(g.cnt));
                end
            end
            if (bus.y_valid && bus.y_ready) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got sel=%0d y=%b expected none", bus.sel, bus.y);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_sel", 32'(bus.sel), 32'(b.sel));
                    check("beat_y", 32'(bus.y), 32'(b.y));
                end
            end
            gnt_last = bus.gnt;
        end
    endtask

    task automatic stimulus();
        logic [3:0] dv;
        // Reset state
        rst         = 1'b1;
        bus.req     = 4'b0000;
        bus.last    = 4'b0000;
        bus.d       = 4'b0000;
        bus.y_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_valid", 32'(bus.y_valid), 32'd0);
        check("rst_grant_cnt", 32'(bus.grant_cnt), 32'd0);

        // Single beat with last from requester 0
        next_cycle();
        bus.req = 4'b0001; bus.d = 4'b0001; bus.y_ready = 1'b1; bus.last = 4'b0001;
        push_grant(4'b0001, 1);
        push_beat(2'd0, 1'b1);
        next_cycle();
        next_cycle();
        bus.req = 4'b0000; bus.last = 4'b0000;
        @(negedge clk);
        check("t1_idle_gnt", 32'(bus.gnt), 32'd0);
        check("t1_grant_cnt", 32'(bus.grant_cnt), 32'd1);

        // Full round robin with MAX_BURST beats each, from a fresh reset
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.req = 4'b1111; bus.d = 4'b1010; bus.y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_grant(4'b0001 << (i % 4), i + 1);
            for (int j = 0; j < 4; j++) push_beat(2'(i % 4), bus.d[i % 4]);
        end
        repeat (25) @(posedge clk);
        #1 bus.req = 4'b0000;
        @(negedge clk);
        check("t2_idle_gnt", 32'(bus.gnt), 32'd0);
        check("t2_grant_cnt", 32'(bus.grant_cnt), 32'd5);

        // Owner 2 stalled by the sink for three cycles
        next_cycle();
        bus.req = 4'b0100; bus.d = 4'b0100; bus.y_ready = 1'b0;
        push_grant(4'b0100, 6);
        for (int j = 0; j < 4; j++) push_beat(2'd2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("t3_stall_valid", 32'(bus.y_valid), 32'd1);
            check("t3_stall_y", 32'(bus.y), 32'd1);
            check("t3_stall_gnt", 32'(bus.gnt), 32'b0100);
        end
        next_cycle();
        bus.y_ready = 1'b1;
        repeat (4) next_cycle();
        bus.req = 4'b0000;
        @(negedge clk);
        check("t3_release_gnt", 32'(bus.gnt), 32'd0);

        // Owner 1 withdraws its request after two transfers
        next_cycle();
        bus.req = 4'b0010; bus.d = 4'b0010;
        push_grant(4'b0010, 7);
        push_beat(2'd1, 1'b1);
        push_beat(2'd1, 1'b1);
        repeat (3) next_cycle();
        bus.req = 4'b0000;
        @(negedge clk);
        check("t4_drop_valid", 32'(bus.y_valid), 32'd0);
        check("t4_drop_gnt_held", 32'(bus.gnt), 32'b0010);
        next_cycle();
        @(negedge clk);
        check("t4_idle_gnt", 32'(bus.gnt), 32'd0);

        // Reset in the middle of a burst, then requester 3 wins from the reset pointer
        bus.req = 4'b0001; bus.d = 4'b0001;
        push_grant(4'b0001, 8);
        push_beat(2'd0, 1'b1);
        push_beat(2'd0, 1'b1);
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.req = 4'b1000; bus.d = 4'b1000;
        push_grant(4'b1000, 1);
        @(negedge clk);
        check("t5_rst_gnt", 32'(bus.gnt), 32'd0);
        check("t5_rst_sel", 32'(bus.sel), 32'd0);
        check("t5_rst_grant_cnt", 32'(bus.grant_cnt), 32'd0);
        next_cycle();
        bus.last = 4'b1000;
        push_beat(2'd3, 1'b1);
        next_cycle();
        bus.req = 4'b0000; bus.last = 4'b0000;
        @(negedge clk);
        check("t5_idle_gnt", 32'(bus.gnt), 32'd0);

        // Static select sweep: y must follow d[sel] for every d
        next_cycle();
        bus.y_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            bus.req = 4'b0001 << s;
            push_grant(4'b0001 << s, s + 2);
            next_cycle();
            check("t6_sel", 32'(bus.sel), 32'(s));
            for (int v = 0; v < 16; v++) begin
                dv    = 4'(v);
                bus.d = dv;
                #1;
                check("t6_y", 32'(bus.y), 32'(dv[s]));
            end
            bus.req = 4'b0000;
            next_cycle();
        end

        repeat (3) next_cycle();
        stim_done = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        stim_done = 1'b0;
        fork
            monitor();
            stimulus();
        join
        check("grant_queue_empty", 32'(grant_q.size()), 32'd0);
        check("beat_queue_empty", 32'(beat_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mx4_rr_scheduler.md
Name: mx4_rr_scheduler

Overview:
- Shares one CC_MX4 4:1 mux between four 1-bit requesters using round-robin arbitration.
- Holds each grant for a burst of beats, then passes the mux on to the next requester.
- Drives the CC_MX4 S0/S1 selects from a registered owner index; the mux output feeds a valid/ready sink.
- Sits in front of shared single-bit resources (debug/status taps) in GateMate fabric tests.

Parameters:
- MAX_BURST, 4, maximum beats transferred per grant; legal range 1..15.
- CNT_W, 4, width of the beat counter and the grant counter; must hold MAX_BURST.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  req[i] high: requester i wants the mux.
- last  input  4  last[i] high: current beat of requester i is its final beat.
- d  input  4  data bit of each requester; drives CC_MX4 D0..D3.
- y_ready  input  1  sink accepts y this cycle.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  owner index; sel[0] drives S0, sel[1] drives S1.
- y  output  1  CC_MX4 Y output, equal to d[sel].
- y_valid  output  1  y carries a valid beat.
- grant_cnt  output  CNT_W  number of grants issued since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state=IDLE, gnt=0000, sel=00, y_valid=0, beat counter=0, grant_cnt=0, round-robin pointer prev=3 (so requester 0 has first priority).
- Reset asserted mid-burst aborts the burst; all outputs take their reset values on the next edge. No beat is transferred while rst=1.
- y is purely combinational through one CC_MX4 instance with selects = sel. No other logic sits in the data path.
- FSM IDLE:
  - gnt=0000, y_valid=0.
  - If req!=0, pick the first set req scanning prev+1, prev+2, prev+3, prev (mod 4).
  - Next edge: state=GRANT, sel=winner, gnt=onehot(winner), prev=winner, beat counter=0, grant_cnt+1.
  - If req=0, stay in IDLE.
- FSM GRANT (owner o=sel):
  - y_valid = req[o], combinational.
  - A beat transfers when y_valid && y_ready; on a transfer the beat counter increments.
  - Release happens on any of:
    - a transfer with last[o]=1;
    - a transfer that makes the counter equal MAX_BURST;
    - req[o]=0, with or without y_ready.
  - On release, the next edge gives state=IDLE, gnt=0000; sel keeps its last value.
  - Otherwise stay in GRANT. If y_ready=0, hold with no counter change.
- Latency:
  - req to gnt: 1 cycle from IDLE.
  - Release to next gnt: 2 cycles (one IDLE cycle is mandatory). Back-to-back grants to the same requester are therefore separated by one idle cycle.
- Other requesters' req and last bits are ignored during GRANT. Requests are not latched; a requester must hold req until granted.
- last[o] without a transfer (y_ready=0) has no effect.
- MAX_BURST=1: every grant releases after its first transfer.
- Simultaneous release and new requests: the new requests are evaluated in IDLE on the following cycle.
- Invariants:
  - gnt is zero or one-hot.
  - gnt!=0 exactly when state=GRANT.
  - y_valid implies gnt[sel]=1.

Test Plan:
- Reset, then req=0001, d=0001, y_ready=1, last=0001 on the first beat -> gnt=0001 after 1 cycle, sel=00, y=1, y_valid=1; one beat, IDLE next, grant_cnt=1.
- req=1111 held, y_ready=1, last=0 -> grant order 0,1,2,3,0. Each grant gives exactly 4 transfers (MAX_BURST=4) and is followed by one IDLE cycle. grant_cnt=5 after the fifth grant.
- Owner 2 granted, d=0100, y_ready low for 3 cycles -> y_valid=1, y=1, beat counter stays 0, gnt=0100 held. Raising y_ready resumes the counting.
- Owner 1 granted, req[1] drops after 2 transfers -> y_valid=0 in that cycle, IDLE next cycle, gnt=0000.
- rst pulsed while in GRANT with counter=2 -> next cycle gnt=0000, sel=00, grant_cnt=0. With req=1000 present, requester 3 is granted.
- Static sweep: for each sel 0..3 in GRANT, drive all 16 values of d -> y=d[sel]. This checks the CC_MX4 wiring of S0/S1.
